// File: rtl/fighter_controller.sv
// Per-player pose/motion generator: one physics step per rising edge of frame_clk.
// Latency: outputs update two Clk edges after frame_clk rises; round_restart acts on the next Clk.
// Backpressure: none; Freeze holds motion while button history keeps sampling.
module fighter_controller #(
    parameter logic [9:0] START_X  = 10'd100,
    parameter logic [9:0] GROUND_Y = 10'd324,
    parameter logic [9:0] X_MAX    = 10'd568,
    parameter logic [9:0] JUMP_V   = 10'd12,
    parameter logic [9:0] HOP_V    = 10'd6,
    parameter logic [9:0] HOP_VX   = 10'd3,
    parameter logic [9:0] KICK_VX  = 10'd6,
    parameter logic [9:0] KICK_VY  = 10'd6,
    parameter logic [9:0] GRAVITY  = 10'd1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       Freeze,
    input  logic       round_restart,
    input  logic       dive,
    input  logic       kick,
    input  logic [9:0] opp_X_Pos,
    output logic [9:0] X_Pos,
    output logic [9:0] Y_Pos,
    output logic [2:0] state
);

    typedef enum logic [1:0] {
        MODE_GROUND = 2'd0,
        MODE_JUMP   = 2'd1,
        MODE_KICK   = 2'd2
    } mode_t;

    localparam logic signed [10:0] JUMP_VY_S = -$signed({1'b0, JUMP_V});
    localparam logic signed [10:0] HOP_VY_S  = -$signed({1'b0, HOP_V});
    localparam logic signed [10:0] HOP_VX_S  = $signed({1'b0, HOP_VX});
    localparam logic signed [10:0] KICK_VX_S = $signed({1'b0, KICK_VX});
    localparam logic signed [10:0] KICK_VY_S = $signed({1'b0, KICK_VY});
    localparam logic signed [10:0] GRAV_S    = $signed({1'b0, GRAVITY});

    logic              frame_d;
    logic              tick;
    logic              dive_prev;
    logic              kick_prev;
    logic              dive_press;
    logic              kick_press;
    logic              face_left;
    logic              opp_left;
    mode_t             mode;
    logic signed [10:0] vx;
    logic signed [10:0] vy;
    logic signed [11:0] sum_x;
    logic signed [11:0] sum_y;
    logic [9:0]         clamp_x;
    logic [9:0]         clamp_y;
    logic               landing;

    // Pose code is the mode offset by 3 when facing left.
    function automatic logic [2:0] pose(input mode_t m, input logic left);
        pose = left ? ({1'b0, m} + 3'd3) : {1'b0, m};
    endfunction

    assign dive_press = dive & ~dive_prev;
    assign kick_press = kick & ~kick_prev;
    assign opp_left   = (opp_X_Pos < X_Pos);

    assign sum_x   = $signed({2'b00, X_Pos}) + $signed({vx[10], vx});
    assign sum_y   = $signed({2'b00, Y_Pos}) + $signed({vy[10], vy});
    assign landing = (sum_y >= $signed({2'b00, GROUND_Y}));

    always_comb begin
        clamp_x = sum_x[9:0];
        if (sum_x < 12'sd0) begin
            clamp_x = 10'd0;
        end else if (sum_x > $signed({2'b00, X_MAX})) begin
            clamp_x = X_MAX;
        end
        clamp_y = sum_y[9:0];
        if (sum_y < 12'sd0) begin
            clamp_y = 10'd0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_d   <= 1'b0;
            tick      <= 1'b0;
            dive_prev <= 1'b0;
            kick_prev <= 1'b0;
            face_left <= 1'b0;
            mode      <= MODE_GROUND;
            vx        <= '0;
            vy        <= '0;
            X_Pos     <= START_X;
            Y_Pos     <= GROUND_Y;
            state     <= 3'd0;
        end else begin
            frame_d <= frame_clk;
            tick    <= frame_clk & ~frame_d;
            if (tick) begin
                dive_prev <= dive;
                kick_prev <= kick;
            end

            if (round_restart) begin
                X_Pos     <= START_X;
                Y_Pos     <= GROUND_Y;
                vx        <= '0;
                vy        <= '0;
                mode      <= MODE_GROUND;
                face_left <= opp_left;
                state     <= pose(MODE_GROUND, opp_left);
            end else if (tick && !Freeze) begin
                case (mode)
                    MODE_GROUND: begin
                        face_left <= opp_left;
                        if (dive_press) begin
                            mode  <= MODE_JUMP;
                            vx    <= '0;
                            vy    <= JUMP_VY_S;
                            state <= pose(MODE_JUMP, opp_left);
                        end else if (kick_press) begin
                            // Back-hop moves away from the opponent.
                            mode  <= MODE_JUMP;
                            vx    <= opp_left ? HOP_VX_S : -HOP_VX_S;
                            vy    <= HOP_VY_S;
                            state <= pose(MODE_JUMP, opp_left);
                        end else begin
                            state <= pose(MODE_GROUND, opp_left);
                        end
                    end
                    MODE_JUMP, MODE_KICK: begin
                        X_Pos <= clamp_x;
                        if (landing) begin
                            Y_Pos <= GROUND_Y;
                            vx    <= '0;
                            vy    <= '0;
                            mode  <= MODE_GROUND;
                            state <= pose(MODE_GROUND, face_left);
                        end else begin
                            Y_Pos <= clamp_y;
                            if (mode == MODE_JUMP && kick_press) begin
                                mode  <= MODE_KICK;
                                vx    <= face_left ? -KICK_VX_S : KICK_VX_S;
                                vy    <= KICK_VY_S;
                                state <= pose(MODE_KICK, face_left);
                            end else if (mode == MODE_JUMP) begin
                                vy <= vy + GRAV_S;
                            end
                        end
                    end
                    default: begin
                        mode  <= MODE_GROUND;
                        state <= pose(MODE_GROUND, face_left);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fighter_controller.sv
// Scoreboard bench for fighter_controller: an integer reference model predicts each frame.
module tb_fighter_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic       Freeze = 1'b0;
    logic       round_restart = 1'b0;
    logic       dive = 1'b0;
    logic       kick = 1'b0;
    logic [9:0] opp_X_Pos = 10'd400;
    logic [9:0] X_Pos;
    logic [9:0] Y_Pos;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] st;
    } snap_t;

    typedef struct packed {
        snap_t pre;
        snap_t post;
    } ent_t;

    ent_t q[$];

    // Reference model state
    int m_x, m_y, m_vx, m_vy, m_mode;
    bit m_left, m_pd, m_pk;

    fighter_controller dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .Freeze       (Freeze),
        .round_restart(round_restart),
        .dive         (dive),
        .kick         (kick),
        .opp_X_Pos    (opp_X_Pos),
        .X_Pos        (X_Pos),
        .Y_Pos        (Y_Pos),
        .state        (state)
    );

    always #10 Clk = ~Clk;

    function automatic snap_t dut_snap();
        snap_t s;
        s.x  = X_Pos;
        s.y  = Y_Pos;
        s.st = state;
        return s;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        int st;
        st   = m_mode + (m_left ? 3 : 0);
        s.x  = 10'(m_x);
        s.y  = 10'(m_y);
        s.st = 3'(st);
        return s;
    endfunction

    task automatic model_reset();
        m_x = 100; m_y = 324; m_vx = 0; m_vy = 0; m_mode = 0;
        m_left = 0; m_pd = 0; m_pk = 0;
    endtask

    task automatic model_step(input bit d, input bit k, input bit fz);
        bit pd, pk;
        int nx, ny;
        pd = d && !m_pd;
        pk = k && !m_pk;
        m_pd = d;
        m_pk = k;
        if (fz) return;
        if (m_mode == 0) begin
            m_left = !(int'(opp_X_Pos) >= m_x);
            if (pd) begin
                m_mode = 1; m_vx = 0; m_vy = -12;
            end else if (pk) begin
                m_mode = 1; m_vy = -6; m_vx = m_left ? 3 : -3;
            end
        end else begin
            nx = m_x + m_vx;
            ny = m_y + m_vy;
            if (nx < 0) nx = 0;
            if (nx > 568) nx = 568;
            m_x = nx;
            if (ny >= 324) begin
                m_y = 324; m_vx = 0; m_vy = 0; m_mode = 0;
            end else begin
                m_y = (ny < 0) ? 0 : ny;
                if (m_mode == 1 && pk) begin
                    m_mode = 2; m_vx = m_left ? -6 : 6; m_vy = 6;
                end else if (m_mode == 1) begin
                    m_vy = m_vy + 1;
                end
            end
        end
    endtask

    // One video frame: raise frame_clk, predict, snapshot DUT 1 and 2 Clk later.
    task automatic frame(input logic d, input logic k, input logic fz,
                         output snap_t early, output snap_t late);
        ent_t e;
        @(negedge Clk);
        dive = d; kick = k; Freeze = fz; frame_clk = 1'b1;
        e.pre = model_snap();
        model_step(d, k, fz);
        e.post = model_snap();
        q.push_back(e);
        @(posedge Clk); #1;
        early = dut_snap();
        @(posedge Clk); #1;
        late = dut_snap();
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset();
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (X_Pos !== 10'd100) begin errors++; $display("FAIL reset_x got %0d want 100", X_Pos); end
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (Y_Pos !== 10'd324) begin errors++; $display("FAIL reset_y got %0d want 324", Y_Pos); end
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_idle();
        snap_t early, late;
        ent_t e;
        opp_X_Pos = 10'd400;
        for (int i = 0; i < 3; i++) begin
            frame(1'b0, 1'b0, 1'b0, early, late);
            if (q.size() == 0) begin checks++; errors++; $display("FAIL idle scoreboard empty"); end
            else begin
                e = q.pop_front();
                checks++;
                if (late !== e.post) begin
                    errors++;
                    $display("FAIL idle_frame got %0d/%0d/%0d want %0d/%0d/%0d",
                             late.x, late.y, late.st, e.post.x, e.post.y, e.post.st);
                end
            end
        end
    endtask

    task automatic test_dive();
        snap_t early, late;
        ent_t e;
        int ydive[3] = '{312, 301, 291};
        opp_X_Pos = 10'd400;
        for (int i = 0; i < 40 && (i == 0 || m_mode != 0); i++) begin
            frame(i == 0, 1'b0, 1'b0, early, late);
            if (q.size() == 0) begin checks++; errors++; $display("FAIL dive scoreboard empty"); end
            else begin
                e = q.pop_front();
                checks++;
                if (early !== e.pre) begin
                    errors++;
                    $display("FAIL dive_latency got %0d/%0d/%0d want %0d/%0d/%0d",
                             early.x, early.y, early.st, e.pre.x, e.pre.y, e.pre.st);
                end
                checks++;
                if (late !== e.post) begin
                    errors++;
                    $display("FAIL dive_frame got %0d/%0d/%0d want %0d/%0d/%0d",
                             late.x, late.y, late.st, e.post.x, e.post.y, e.post.st);
                end
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (late.y !== 10'(ydive[i-1]) || late.st !== 3'd1) begin
                    errors++;
                    $display("FAIL dive_arc got y=%0d st=%0d want y=%0d st=1", late.y, late.st, ydive[i-1]);
                end
            end
        end
        checks++;
        if (m_mode != 0 || Y_Pos !== 10'd324 || state !== 3'd0) begin
            errors++;
            $display("FAIL dive_landing got y=%0d st=%0d want y=324 st=0", Y_Pos, state);
        end
    endtask

    task automatic test_dive_kick();
        snap_t early, late;
        ent_t e;
        bit kicked;
        opp_X_Pos = 10'd50;
        kicked = 0;
        for (int i = 0; i < 60 && (i == 0 || m_mode != 0); i++) begin
            logic k;
            k = (m_mode == 1 && m_vy >= 0 && !kicked);
            if (k) kicked = 1;
            frame(i == 0, k, 1'b0, early, late);
            if (q.size() == 0) begin checks++; errors++; $display("FAIL divekick scoreboard empty"); end
            else begin
                e = q.pop_front();
                checks++;
                if (late !== e.post) begin
                    errors++;
                    $display("FAIL divekick_frame got %0d/%0d/%0d want %0d/%0d/%0d",
                             late.x, late.y, late.st, e.post.x, e.post.y, e.post.st);
                end
            end
        end
        checks++;
        if (!kicked || state !== 3'd3 || Y_Pos !== 10'd324) begin
            errors++;
            $display("FAIL divekick_landing got y=%0d st=%0d want y=324 st=3", Y_Pos, state);
        end
    endtask

    task automatic test_hop_clamp();
        snap_t early, late;
        ent_t e;
        opp_X_Pos = 10'd600;
        for (int h = 0; h < 6 && m_x > 0; h++) begin
            for (int i = 0; i < 40 && (i == 0 || m_mode != 0); i++) begin
                frame(1'b0, i == 0, 1'b0, early, late);
                if (q.size() == 0) begin checks++; errors++; $display("FAIL hop scoreboard empty"); end
                else begin
                    e = q.pop_front();
                    checks++;
                    if (late !== e.post) begin
                        errors++;
                        $display("FAIL hop_frame got %0d/%0d/%0d want %0d/%0d/%0d",
                                 late.x, late.y, late.st, e.post.x, e.post.y, e.post.st);
                    end
                end
            end
        end
        checks++;
        if (X_Pos !== 10'd0) begin errors++; $display("FAIL hop_clamp got x=%0d want 0", X_Pos); end
    endtask

    task automatic test_freeze();
        snap_t early, late, held;
        ent_t e;
        opp_X_Pos = 10'd400;
        for (int i = 0; i < 60 && (i == 0 || m_mode != 0); i++) begin
            logic fz, d;
            fz = (i >= 4 && i < 9);
            d  = (i == 0 || i == 6);
            if (i == 4) held = dut_snap();
            frame(d, 1'b0, fz, early, late);
            if (q.size() == 0) begin checks++; errors++; $display("FAIL freeze scoreboard empty"); end
            else begin
                e = q.pop_front();
                checks++;
                if (late !== e.post) begin
                    errors++;
                    $display("FAIL freeze_frame got %0d/%0d/%0d want %0d/%0d/%0d",
                             late.x, late.y, late.st, e.post.x, e.post.y, e.post.st);
                end
            end
            if (fz) begin
                checks++;
                if (late !== held) begin
                    errors++;
                    $display("FAIL freeze_hold got %0d/%0d/%0d want %0d/%0d/%0d",
                             late.x, late.y, late.st, held.x, held.y, held.st);
                end
            end
        end
    endtask

    task automatic test_reset_async();
        snap_t early, late;
        ent_t e;
        opp_X_Pos = 10'd50;
        for (int i = 0; i < 30 && m_mode != 2; i++) begin
            frame(i == 0, (m_mode == 1 && m_vy >= -2), 1'b0, early, late);
            if (q.size() == 0) begin checks++; errors++; $display("FAIL rstkick scoreboard empty"); end
            else begin
                e = q.pop_front();
                checks++;
                if (late !== e.post) begin
                    errors++;
                    $display("FAIL rstkick_frame got %0d/%0d/%0d want %0d/%0d/%0d",
                             late.x, late.y, late.st, e.post.x, e.post.y, e.post.st);
                end
            end
        end
        frame(1'b0, 1'b0, 1'b0, early, late);
        void'(q.pop_front());
        @(posedge Clk);
        #3 Reset = 1'b1;
        #1;
        checks++;
        if (X_Pos !== 10'd100 || Y_Pos !== 10'd324 || state !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got %0d/%0d/%0d want 100/324/0", X_Pos, Y_Pos, state);
        end
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        q.delete();
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_restart_freeze();
        snap_t early, late;
        ent_t e;
        opp_X_Pos = 10'd400;
        for (int i = 0; i < 4; i++) begin
            frame(i == 0, 1'b0, 1'b0, early, late);
            void'(q.pop_front());
        end
        checks++;
        if (Y_Pos === 10'd324) begin errors++; $display("FAIL restart_setup got y=%0d want airborne", Y_Pos); end
        @(negedge Clk);
        Freeze = 1'b1;
        round_restart = 1'b1;
        m_left = !(int'(opp_X_Pos) >= m_x);
        m_x = 100; m_y = 324; m_vx = 0; m_vy = 0; m_mode = 0;
        @(posedge Clk); #1;
        checks++;
        if (X_Pos !== 10'd100 || Y_Pos !== 10'd324 || state !== 3'd0) begin
            errors++;
            $display("FAIL restart_pose got %0d/%0d/%0d want 100/324/0", X_Pos, Y_Pos, state);
        end
        @(negedge Clk);
        round_restart = 1'b0;
        Freeze = 1'b0;
        frame(1'b0, 1'b0, 1'b0, early, late);
        if (q.size() == 0) begin checks++; errors++; $display("FAIL restart scoreboard empty"); end
        else begin
            e = q.pop_front();
            checks++;
            if (late !== e.post) begin
                errors++;
                $display("FAIL restart_frame got %0d/%0d/%0d want %0d/%0d/%0d",
                         late.x, late.y, late.st, e.post.x, e.post.y, e.post.st);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_dive();
        test_dive_kick();
        test_hop_clamp();
        test_freeze();
        test_reset_async();
        test_restart_freeze();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
